// File: rtl/freq_ratio_meter_pkg.sv
// Shared types and defaults for the frequency/ratio meter.
package freq_ratio_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_STALL   = 2'd2
  } meter_state_e;

  localparam int DEF_CNT_W       = 8;
  localparam int DEF_LOCK_N      = 4;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/freq_ratio_meter_sync_edge_detect.sv
// Synchroniser chain plus registered rising-edge detect; level and rise are
// both registered so they stay aligned with each other.
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              s_prev;
  logic              rise_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      s_prev <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      s_prev <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~s_prev;
    end
  end

  // s_prev is the sample that produced rise_q, so it is the level for that cycle
  assign level = s_prev;
  assign rise  = rise_q;

endmodule

// File: rtl/freq_ratio_meter.sv
// Measures period and high time of an asynchronous periodic signal in clk
// cycles, declares lock on repeated equal periods, flags a stalled signal.
module freq_ratio_meter
  import freq_ratio_meter_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int LOCK_N      = DEF_LOCK_N,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             clear,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_MAX - 1'b1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam int               MW        = $clog2(LOCK_N);
  localparam logic [MW-1:0]    MATCH_TOP = MW'(LOCK_N - 1);

  logic             srst;
  logic             lvl;
  logic             rise;

  meter_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [MW-1:0]    match_q, match_d;
  logic [CNT_W-1:0] period_d, high_d;
  logic             mv_d, locked_d, timeout_d;

  assign srst = rst | clear;

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst   (srst),
    .d     (sig_in),
    .level (lvl),
    .rise  (rise)
  );

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      hcnt_q     <= '0;
      match_q    <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hcnt_q     <= hcnt_d;
      match_q    <= match_d;
      period     <= period_d;
      high_time  <= high_d;
      meas_valid <= mv_d;
      locked     <= locked_d;
      timeout    <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    match_d   = match_q;
    period_d  = period;
    high_d    = high_time;
    mv_d      = 1'b0;
    locked_d  = locked;
    timeout_d = timeout;

    unique case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_MEASURE;
          cnt_d   = CNT_ONE;
          hcnt_d  = CNT_ONE;
        end else if (cnt_q >= CNT_LAST) begin
          state_d   = ST_STALL;
          cnt_d     = CNT_MAX;
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          match_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_MEASURE: begin
        if (rise) begin
          period_d = cnt_q;
          high_d   = hcnt_q;
          mv_d     = 1'b1;
          cnt_d    = CNT_ONE;
          hcnt_d   = CNT_ONE;
          // compare against the period still held from the previous measurement
          if (cnt_q == period) begin
            if (match_q != MATCH_TOP) match_d = match_q + 1'b1;
          end else begin
            match_d = '0;
          end
          locked_d = (match_d == MATCH_TOP);
        end else if (cnt_q >= CNT_LAST) begin
          state_d   = ST_STALL;
          cnt_d     = CNT_MAX;
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          match_d   = '0;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          hcnt_d = hcnt_q + CNT_W'(lvl);
        end
      end

      ST_STALL: begin
        if (rise) begin
          state_d   = ST_MEASURE;
          cnt_d     = CNT_ONE;
          hcnt_d    = CNT_ONE;
          timeout_d = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule
